// File: rtl/imem_dmem_bus_arbiter.sv
// Shares one memory port between I-cache and D-cache with D priority and I starvation relief.
// Zero added latency on request and return paths; no backpressure beyond memory response 0 (busy).
module imem_dmem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int NUM_TAGS     = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  Icache_command,
  input  logic [63:0] Icache_addr,
  input  logic [1:0]  Dcache_command,
  input  logic [63:0] Dcache_addr,
  input  logic [63:0] Dcache_data,
  input  logic [3:0]  mem2proc_response,
  input  logic [63:0] mem2proc_data,
  input  logic [3:0]  mem2proc_tag,
  output logic [1:0]  proc2mem_command,
  output logic [63:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  output logic [3:0]  Imem2proc_response,
  output logic [3:0]  Imem2proc_tag,
  output logic [3:0]  Dmem2proc_response,
  output logic [3:0]  Dmem2proc_tag,
  output logic [63:0] mem2cache_data,
  output logic        grant_dcache,
  output logic        stray_tag
);

  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_LOAD  = 2'h1;
  localparam logic [1:0] BUS_STORE = 2'h2;

  localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef struct packed {
    logic [1:0]  command;
    logic [63:0] addr;
    logic [63:0] data;
  } mem_req_t;

  logic                i_req;
  logic                d_req;
  logic                starved;
  logic                grant_d;
  logic                grant_i;
  logic                resp_nz;
  logic                load_accept;
  logic                ret_hit;
  logic                ret_stray;
  mem_req_t            fwd;
  logic [CNT_W-1:0]    starve_cnt;
  logic [CNT_W-1:0]    starve_cnt_nxt;
  logic [NUM_TAGS-1:0] owner_valid;
  logic [NUM_TAGS-1:0] owner_valid_nxt;
  logic [NUM_TAGS-1:0] owner_is_d;
  logic [NUM_TAGS-1:0] owner_is_d_nxt;

  assign i_req   = (Icache_command != BUS_NONE);
  assign d_req   = (Dcache_command != BUS_NONE);
  assign starved = (starve_cnt >= LIMIT);
  assign grant_d = d_req && !(i_req && starved);
  assign grant_i = i_req && !grant_d;
  assign resp_nz = (mem2proc_response != 4'h0);

  // I side only ever loads, so any I command is forwarded as a load.
  always_comb begin
    fwd = '0;
    if (grant_d) begin
      fwd.command = Dcache_command;
      fwd.addr    = Dcache_addr;
      fwd.data    = Dcache_data;
    end else if (grant_i) begin
      fwd.command = BUS_LOAD;
      fwd.addr    = Icache_addr;
    end
  end

  // Stores never return data, so only accepted loads claim a tag.
  assign load_accept = !reset && (fwd.command == BUS_LOAD) && resp_nz
                       && (fwd.command != BUS_STORE);
  assign ret_hit     = (mem2proc_tag != 4'h0) && owner_valid[mem2proc_tag];
  assign ret_stray   = (mem2proc_tag != 4'h0) && !owner_valid[mem2proc_tag];

  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (!i_req) begin
      starve_cnt_nxt = '0;
    end else if (!grant_i) begin
      if (!starved) starve_cnt_nxt = starve_cnt + CNT_W'(1);
    end else if (resp_nz) begin
      starve_cnt_nxt = '0;
    end
  end

  // Retire before record: a same-cycle return and accept of one tag leaves it owned.
  always_comb begin
    owner_valid_nxt = owner_valid;
    owner_is_d_nxt  = owner_is_d;
    if (ret_hit) owner_valid_nxt[mem2proc_tag] = 1'b0;
    if (load_accept) begin
      owner_valid_nxt[mem2proc_response] = 1'b1;
      owner_is_d_nxt[mem2proc_response]  = grant_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt  <= '0;
      owner_valid <= '0;
      owner_is_d  <= '0;
    end else begin
      starve_cnt  <= starve_cnt_nxt;
      owner_valid <= owner_valid_nxt;
      owner_is_d  <= owner_is_d_nxt;
    end
  end

  always_comb begin
    proc2mem_command   = BUS_NONE;
    proc2mem_addr      = '0;
    proc2mem_data      = '0;
    Imem2proc_response = '0;
    Dmem2proc_response = '0;
    Imem2proc_tag      = '0;
    Dmem2proc_tag      = '0;
    mem2cache_data     = '0;
    grant_dcache       = 1'b0;
    stray_tag          = 1'b0;
    if (!reset) begin
      proc2mem_command = fwd.command;
      proc2mem_addr    = fwd.addr;
      proc2mem_data    = fwd.data;
      grant_dcache     = grant_d;
      mem2cache_data   = mem2proc_data;
      stray_tag        = ret_stray;
      if (grant_d) Dmem2proc_response = mem2proc_response;
      if (grant_i) Imem2proc_response = mem2proc_response;
      if (ret_hit) begin
        if (owner_is_d[mem2proc_tag]) Dmem2proc_tag = mem2proc_tag;
        else                          Imem2proc_tag = mem2proc_tag;
      end
    end
  end

endmodule

// File: tb/tb_imem_dmem_bus_arbiter.sv
// Directed bench for imem_dmem_bus_arbiter: inputs change on negedge, outputs checked 1ns later.
module tb_imem_dmem_bus_arbiter;

  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_LOAD  = 2'h1;
  localparam logic [1:0] BUS_STORE = 2'h2;

  logic        clock;
  logic        reset;
  logic [1:0]  Icache_command;
  logic [63:0] Icache_addr;
  logic [1:0]  Dcache_command;
  logic [63:0] Dcache_addr;
  logic [63:0] Dcache_data;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  Imem2proc_response;
  logic [3:0]  Imem2proc_tag;
  logic [3:0]  Dmem2proc_response;
  logic [3:0]  Dmem2proc_tag;
  logic [63:0] mem2cache_data;
  logic        grant_dcache;
  logic        stray_tag;

  int passed = 0;
  int total  = 0;

  imem_dmem_bus_arbiter #(.STARVE_LIMIT(4), .NUM_TAGS(16)) dut (
    .clock(clock), .reset(reset),
    .Icache_command(Icache_command), .Icache_addr(Icache_addr),
    .Dcache_command(Dcache_command), .Dcache_addr(Dcache_addr), .Dcache_data(Dcache_data),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
    .mem2proc_tag(mem2proc_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data),
    .Imem2proc_response(Imem2proc_response), .Imem2proc_tag(Imem2proc_tag),
    .Dmem2proc_response(Dmem2proc_response), .Dmem2proc_tag(Dmem2proc_tag),
    .mem2cache_data(mem2cache_data), .grant_dcache(grant_dcache), .stray_tag(stray_tag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic drive(input logic [1:0] icmd, input logic [63:0] iaddr,
                       input logic [1:0] dcmd, input logic [63:0] daddr,
                       input logic [63:0] ddata, input logic [3:0] resp,
                       input logic [3:0] rtag);
    Icache_command    = icmd;
    Icache_addr       = iaddr;
    Dcache_command    = dcmd;
    Dcache_addr       = daddr;
    Dcache_data       = ddata;
    mem2proc_response = resp;
    mem2proc_tag      = rtag;
    #1;
  endtask

  task automatic idle(input logic [3:0] rtag);
    drive(BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'h0, rtag);
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem2proc_data = 64'h55AA;
    drive(BUS_LOAD, 64'h100, BUS_STORE, 64'h200, 64'hBEEF, 4'h3, 4'h3);
    total++;
    if ({proc2mem_command, proc2mem_addr, proc2mem_data, grant_dcache, stray_tag} !== '0)
      $display("FAIL reset_fwd got cmd=%0h addr=%0h data=%0h g=%0b s=%0b want all 0",
               proc2mem_command, proc2mem_addr, proc2mem_data, grant_dcache, stray_tag);
    else passed++;
    total++;
    if ({Imem2proc_response, Dmem2proc_response, Imem2proc_tag, Dmem2proc_tag, mem2cache_data} !== '0)
      $display("FAIL reset_rsp got ir=%0h dr=%0h it=%0h dt=%0h md=%0h want all 0",
               Imem2proc_response, Dmem2proc_response, Imem2proc_tag, Dmem2proc_tag, mem2cache_data);
    else passed++;
    step();
    reset = 1'b0;
    mem2proc_data = 64'h0;
    idle(4'h0);
    step();
  endtask

  task automatic test_idle();
    for (int c = 0; c < 5; c++) begin
      idle(4'h0);
      total++;
      if ({proc2mem_command, Imem2proc_response, Dmem2proc_response, Imem2proc_tag,
           Dmem2proc_tag, grant_dcache, stray_tag} !== '0)
        $display("FAIL idle_%0d got cmd=%0h ir=%0h dr=%0h it=%0h dt=%0h g=%0b s=%0b want 0",
                 c, proc2mem_command, Imem2proc_response, Dmem2proc_response,
                 Imem2proc_tag, Dmem2proc_tag, grant_dcache, stray_tag);
      else passed++;
      step();
    end
  endtask

  task automatic test_i_load();
    drive(BUS_LOAD, 64'h100, BUS_NONE, 64'h0, 64'h0, 4'h3, 4'h0);
    total++;
    if ({proc2mem_command, proc2mem_addr, proc2mem_data, grant_dcache} !== {BUS_LOAD, 64'h100, 64'h0, 1'b0})
      $display("FAIL iload_fwd got cmd=%0h addr=%0h data=%0h g=%0b want 1/100/0/0",
               proc2mem_command, proc2mem_addr, proc2mem_data, grant_dcache);
    else passed++;
    total++;
    if ({Imem2proc_response, Dmem2proc_response} !== {4'h3, 4'h0})
      $display("FAIL iload_resp got ir=%0h dr=%0h want 3/0", Imem2proc_response, Dmem2proc_response);
    else passed++;
    step();
    for (int c = 0; c < 9; c++) begin idle(4'h0); step(); end
    mem2proc_data = 64'h1234;
    idle(4'h3);
    total++;
    if ({Imem2proc_tag, Dmem2proc_tag, stray_tag, mem2cache_data} !== {4'h3, 4'h0, 1'b0, 64'h1234})
      $display("FAIL iload_ret got it=%0h dt=%0h s=%0b md=%0h want 3/0/0/1234",
               Imem2proc_tag, Dmem2proc_tag, stray_tag, mem2cache_data);
    else passed++;
    step();
    mem2proc_data = 64'h0;
    idle(4'h3);
    total++;
    if ({stray_tag, Imem2proc_tag} !== {1'b1, 4'h0})
      $display("FAIL iload_cleared got s=%0b it=%0h want 1/0", stray_tag, Imem2proc_tag);
    else passed++;
    step();
    idle(4'h0);
    step();
  endtask

  task automatic test_contention();
    bit exp_d [0:7];
    logic [3:0] t;
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 8; k++) begin
      t = 4'(k + 1);
      drive(BUS_LOAD, 64'h1000 + 64'(k), BUS_LOAD, 64'h2000 + 64'(k), 64'h0, t, 4'h0);
      total++;
      if (grant_dcache !== exp_d[k] ||
          Dmem2proc_response !== (exp_d[k] ? t : 4'h0) ||
          Imem2proc_response !== (exp_d[k] ? 4'h0 : t))
        $display("FAIL contend_%0d got g=%0b ir=%0h dr=%0h want g=%0b tag=%0h",
                 k, grant_dcache, Imem2proc_response, Dmem2proc_response, exp_d[k], t);
      else passed++;
      step();
    end
    idle(4'h0);
    step();
    for (int k = 0; k < 8; k++) begin
      t = 4'(k + 1);
      idle(t);
      total++;
      if (Imem2proc_tag !== (exp_d[k] ? 4'h0 : t) || Dmem2proc_tag !== (exp_d[k] ? t : 4'h0))
        $display("FAIL contend_ret_%0d got it=%0h dt=%0h want owner d=%0b tag=%0h",
                 k, Imem2proc_tag, Dmem2proc_tag, exp_d[k], t);
      else passed++;
      step();
    end
    idle(4'h0);
    step();
  endtask

  task automatic test_busy();
    for (int c = 0; c < 4; c++) begin
      drive(BUS_LOAD, 64'h3000, BUS_LOAD, 64'h4000, 64'h0, 4'h0, 4'h0);
      total++;
      if (grant_dcache !== 1'b1)
        $display("FAIL busy_pre_%0d got g=%0b want 1", c, grant_dcache);
      else passed++;
      step();
    end
    for (int c = 0; c < 6; c++) begin
      drive(BUS_LOAD, 64'h3000, BUS_LOAD, 64'h4000, 64'h0, 4'h0, 4'h0);
      total++;
      if ({grant_dcache, Dmem2proc_response, proc2mem_addr} !== {1'b0, 4'h0, 64'h3000})
        $display("FAIL busy_hold_%0d got g=%0b dr=%0h addr=%0h want 0/0/3000",
                 c, grant_dcache, Dmem2proc_response, proc2mem_addr);
      else passed++;
      step();
    end
    drive(BUS_LOAD, 64'h3000, BUS_LOAD, 64'h4000, 64'h0, 4'h9, 4'h0);
    total++;
    if ({grant_dcache, Imem2proc_response, Dmem2proc_response} !== {1'b0, 4'h9, 4'h0})
      $display("FAIL busy_accept got g=%0b ir=%0h dr=%0h want 0/9/0",
               grant_dcache, Imem2proc_response, Dmem2proc_response);
    else passed++;
    step();
    drive(BUS_LOAD, 64'h3000, BUS_LOAD, 64'h4000, 64'h0, 4'h0, 4'h0);
    total++;
    if (grant_dcache !== 1'b1)
      $display("FAIL busy_after got g=%0b want 1", grant_dcache);
    else passed++;
    step();
    idle(4'h9);
    total++;
    if ({Imem2proc_tag, Dmem2proc_tag} !== {4'h9, 4'h0})
      $display("FAIL busy_ret got it=%0h dt=%0h want 9/0", Imem2proc_tag, Dmem2proc_tag);
    else passed++;
    step();
  endtask

  task automatic test_store();
    drive(BUS_NONE, 64'h0, BUS_STORE, 64'h200, 64'hDEAD, 4'h5, 4'h0);
    total++;
    if ({proc2mem_command, proc2mem_addr, proc2mem_data, grant_dcache, Dmem2proc_response}
        !== {BUS_STORE, 64'h200, 64'hDEAD, 1'b1, 4'h5})
      $display("FAIL store_fwd got cmd=%0h addr=%0h data=%0h g=%0b dr=%0h want 2/200/dead/1/5",
               proc2mem_command, proc2mem_addr, proc2mem_data, grant_dcache, Dmem2proc_response);
    else passed++;
    step();
    idle(4'h0);
    step();
    idle(4'h5);
    total++;
    if ({stray_tag, Imem2proc_tag, Dmem2proc_tag} !== {1'b1, 4'h0, 4'h0})
      $display("FAIL store_ret got s=%0b it=%0h dt=%0h want 1/0/0",
               stray_tag, Imem2proc_tag, Dmem2proc_tag);
    else passed++;
    step();
  endtask

  task automatic test_back_to_back_tag();
    drive(BUS_NONE, 64'h0, BUS_LOAD, 64'h400, 64'h0, 4'h6, 4'h0);
    step();
    idle(4'h0);
    step();
    // I issues a store-encoded command: forwarded as load and takes over tag 6 while D's 6 returns.
    drive(BUS_STORE, 64'h500, BUS_NONE, 64'h0, 64'h0, 4'h6, 4'h6);
    total++;
    if ({proc2mem_command, Imem2proc_response, Dmem2proc_tag, Imem2proc_tag}
        !== {BUS_LOAD, 4'h6, 4'h6, 4'h0})
      $display("FAIL b2b_same got cmd=%0h ir=%0h dt=%0h it=%0h want 1/6/6/0",
               proc2mem_command, Imem2proc_response, Dmem2proc_tag, Imem2proc_tag);
    else passed++;
    step();
    idle(4'h6);
    total++;
    if ({Imem2proc_tag, Dmem2proc_tag, stray_tag} !== {4'h6, 4'h0, 1'b0})
      $display("FAIL b2b_new_owner got it=%0h dt=%0h s=%0b want 6/0/0",
               Imem2proc_tag, Dmem2proc_tag, stray_tag);
    else passed++;
    step();
    idle(4'h0);
    step();
  endtask

  task automatic test_reset_mid();
    drive(BUS_LOAD, 64'h700, BUS_NONE, 64'h0, 64'h0, 4'h7, 4'h0);
    total++;
    if (Imem2proc_response !== 4'h7)
      $display("FAIL rmid_accept got ir=%0h want 7", Imem2proc_response);
    else passed++;
    step();
    reset = 1'b1;
    drive(BUS_LOAD, 64'h710, BUS_LOAD, 64'h720, 64'h1, 4'h8, 4'h7);
    total++;
    if ({proc2mem_command, proc2mem_addr, grant_dcache, stray_tag,
         Imem2proc_response, Dmem2proc_response, Imem2proc_tag, Dmem2proc_tag} !== '0)
      $display("FAIL rmid_forced got cmd=%0h addr=%0h g=%0b s=%0b ir=%0h dr=%0h it=%0h dt=%0h want 0",
               proc2mem_command, proc2mem_addr, grant_dcache, stray_tag,
               Imem2proc_response, Dmem2proc_response, Imem2proc_tag, Dmem2proc_tag);
    else passed++;
    step();
    reset = 1'b0;
    idle(4'h7);
    total++;
    if ({stray_tag, Imem2proc_tag, Dmem2proc_tag} !== {1'b1, 4'h0, 4'h0})
      $display("FAIL rmid_orphan got s=%0b it=%0h dt=%0h want 1/0/0",
               stray_tag, Imem2proc_tag, Dmem2proc_tag);
    else passed++;
    step();
    idle(4'h8);
    total++;
    if (stray_tag !== 1'b1)
      $display("FAIL rmid_no_write got s=%0b want 1", stray_tag);
    else passed++;
    step();
  endtask

  initial begin
    reset = 1'b1;
    mem2proc_data = 64'h0;
    Icache_command = BUS_NONE; Icache_addr = '0;
    Dcache_command = BUS_NONE; Dcache_addr = '0; Dcache_data = '0;
    mem2proc_response = '0; mem2proc_tag = '0;
    step();
    test_reset();
    test_idle();
    test_i_load();
    test_contention();
    test_busy();
    test_store();
    test_back_to_back_tag();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/imem_dmem_bus_arbiter.md
Name: imem_dmem_bus_arbiter

Overview:
Shares the single off-chip memory port between the instruction-cache controller (I side) and the data-cache controller (D side). Each cycle it picks one requester and forwards its command, address and data to memory. It returns the memory's immediate response tag to the winner only. It tracks which side owns every outstanding transaction tag, so that late data returns (mem2proc_tag) are steered to the correct controller. D side has priority, bounded by an I-side starvation limit.

Parameters:
STARVE_LIMIT, 4, consecutive denied I-side request cycles after which I side wins the next contested cycle
NUM_TAGS, 16, number of memory transaction tags (tag 0 = no transaction); fixed by the 4-bit tag width

Ports:
clock  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-high reset
Icache_command  in  2  I-side request (`BUS_NONE/`BUS_LOAD; `BUS_STORE never issued by I side, treated as load)
Icache_addr  in  64  I-side address
Dcache_command  in  2  D-side request (`BUS_NONE/`BUS_LOAD/`BUS_STORE)
Dcache_addr  in  64  D-side address
Dcache_data  in  64  D-side store data
mem2proc_response  in  4  memory accept tag this cycle, 0 = not accepted
mem2proc_data  in  64  memory return data
mem2proc_tag  in  4  tag of returning data, 0 = none
proc2mem_command  out  2  forwarded command
proc2mem_addr  out  64  forwarded address
proc2mem_data  out  64  forwarded store data (Dcache_data when D granted, else 0)
Imem2proc_response  out  4  accept tag to I side
Imem2proc_tag  out  4  returning tag to I side
Dmem2proc_response  out  4  accept tag to D side
Dmem2proc_tag  out  4  returning tag to D side
mem2cache_data  out  64  mem2proc_data, broadcast to both sides
grant_dcache  out  1  1 = D side owns the bus this cycle
stray_tag  out  1  one-cycle pulse: nonzero mem2proc_tag with no recorded owner

Behaviour:
- Grant is combinational from the current requests and the registered starve counter.
  - D only -> D.
  - I only -> I.
  - Both -> D, unless starve_cnt >= STARVE_LIMIT, then I.
  - Neither -> proc2mem_command = `BUS_NONE, grant_dcache = 0.
- Forwarding: proc2mem_command/addr/data come from the granted side; non-granted side's response output = 0.
- Granted side's response output = mem2proc_response (same cycle, zero latency).
- starve_cnt (3+ bits, saturating at STARVE_LIMIT):
  - +1 on each cycle I requests and is not granted.
  - Cleared when I is granted and mem2proc_response != 0.
  - Unchanged when I is granted but memory returns response 0 (busy); I keeps priority until accepted.
  - Cleared when I is not requesting.
- Ownership table: per tag t in 1..15, owner_valid[t] and owner_is_d[t].
  - Write: a granted `BUS_LOAD with mem2proc_response = t != 0 sets owner_valid[t] = 1 and owner_is_d[t] = grant_dcache.
  - Stores: a granted `BUS_STORE records nothing (no data return).
- Return routing (combinational on the current table):
  - If mem2proc_tag = t != 0 and owner_valid[t], drive t on that owner's tag output, 0 on the other; owner_valid[t] clears next edge.
  - If owner_valid[t] = 0, both tag outputs = 0 and stray_tag = 1 this cycle.
- Simultaneous return of tag t and new accept with tag t in the same cycle: the return is routed using the old owner; the new accept's write wins, so owner_valid[t] = 1 afterwards.
- Reset (synchronous, dominant, including mid-transaction):
  - Registered state: starve_cnt = 0, all owner_valid = 0.
  - While reset is high, every output is forced to 0: proc2mem_command = `BUS_NONE, addr/data 0, response and tag outputs 0, grant_dcache 0, stray_tag 0.
  - Tags outstanding across reset are orphaned; their later return raises stray_tag.
- No other latency; the block adds zero cycles to the request path and the return path.

Test Plan:
- Idle: both commands `BUS_NONE for 5 cycles -> proc2mem_command = `BUS_NONE, all tag/response outputs 0, starve_cnt 0.
- I-only load, addr 0x100, mem response 3; 10 cycles later mem2proc_tag = 3 -> Imem2proc_response = 3 same cycle; Imem2proc_tag = 3, Dmem2proc_tag = 0 at return; owner_valid[3] cleared after.
- Contention: both request loads every cycle, memory accepts each with tags 1,2,3,... -> D granted 4 consecutive cycles, I granted 5th, then D again; starve_cnt resets after the I accept.
- Busy memory: both request, response 0 for 6 cycles after starve limit reached -> I keeps grant every cycle until response nonzero; D sees Dmem2proc_response = 0 throughout.
- D store addr 0x200 data 0xDEAD, response 5; later mem2proc_tag = 5 -> proc2mem_data = 0xDEAD; no owner recorded; stray_tag = 1 at return, both tag outputs 0.
- Reset mid-flight: I load accepted with tag 7, reset 1 cycle, then mem2proc_tag = 7 -> outputs zero during reset; after reset stray_tag = 1, Imem2proc_tag = 0.
